// File: rtl/host_switch_ctrl_pkg.sv
// Purpose: shared types and timing defaults for the host switch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package host_switch_ctrl_pkg;

    // Oscillator frequency the default timeouts are derived from.
    localparam int unsigned OSC_HZ = 50_000_000;

    // 20 ms of heartbeat silence declares a CPU dead; 20 us break-before-make.
    localparam logic [31:0] HB_TIMEOUT_DEF = 32'(OSC_HZ / 50);
    localparam logic [15:0] GUARD_CYC_DEF  = 16'(OSC_HZ / 50_000);

    typedef enum logic [1:0] {
        A_HOST     = 2'd0,
        GUARD_TO_B = 2'd1,
        B_HOST     = 2'd2,
        GUARD_TO_A = 2'd3
    } host_state_t;

    // A zero-length guard would let both enables overlap; clamp it to one cycle.
    function automatic logic [15:0] guard_len(input logic [15:0] cyc);
        return (cyc == 16'd0) ? 16'd1 : cyc;
    endfunction

endpackage

// File: rtl/hb_watchdog.sv
// Purpose: per-CPU heartbeat watchdog (2-flop sync, any-edge detect, saturating counter, fault flag).
// Latency: heartbeat edge clears the counter 3 cycles after the pin toggles; fault is registered.
// Backpressure: none; free-running monitor.
// Ports: clk, rst_n; hb (async heartbeat), power_on, reset_sig (CPU state); fault (CPU dead).
module hb_watchdog
    import host_switch_ctrl_pkg::*;
#(
    parameter logic [31:0] HB_TIMEOUT = HB_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hb,
    input  logic power_on,
    input  logic reset_sig,
    output logic fault
);

    // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect.
    logic [2:0]  hb_sync;
    logic        hb_edge;
    logic        hold;
    logic [31:0] cnt;
    logic [31:0] cnt_nxt;

    assign hb_edge = hb_sync[2] ^ hb_sync[1];
    // A CPU that is off or in reset cannot heartbeat; keep its count parked at 0
    // so it is judged afresh once it comes back.
    assign hold    = reset_sig | ~power_on;

    always_comb begin
        cnt_nxt = cnt;
        if (hold || hb_edge) begin
            cnt_nxt = 32'd0;
        end else if (cnt != HB_TIMEOUT) begin
            cnt_nxt = cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_sync <= 3'b000;
            cnt     <= 32'd0;
            fault   <= 1'b0;
        end else begin
            hb_sync <= {hb_sync[1:0], hb};
            cnt     <= cnt_nxt;
            fault   <= hold | (cnt_nxt == HB_TIMEOUT);
        end
    end

endmodule

// File: rtl/host_switch_ctrl.sv
// Purpose: selects which CPU owns the host bus, with break-before-make guard on every change.
// Latency: force_swi at cycle N -> guard at N+1 -> new host/enables/swi_event at N+1+GUARD_CYC.
// Backpressure: requests arriving during a guard are dropped, not queued.
// Ports: clk, rst_n; hb_a/hb_b heartbeats; force_swi/com_swi operator request;
//        reset_*_signal, power_on_* CPU state; switch, host_en_*, fault_*, both_fail, swi_event.
module host_switch_ctrl
    import host_switch_ctrl_pkg::*;
#(
    parameter logic [31:0] HB_TIMEOUT = HB_TIMEOUT_DEF,
    parameter logic [15:0] GUARD_CYC  = GUARD_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hb_a,
    input  logic hb_b,
    input  logic force_swi,
    input  logic com_swi,
    input  logic reset_a_signal,
    input  logic reset_b_signal,
    input  logic power_on_A,
    input  logic power_on_B,
    output logic switch,
    output logic host_en_a,
    output logic host_en_b,
    output logic fault_a,
    output logic fault_b,
    output logic both_fail,
    output logic swi_event
);

    localparam logic [15:0] GUARD_LAST = guard_len(GUARD_CYC) - 16'd1;

    host_state_t state;
    logic [15:0] guard_cnt;

    hb_watchdog #(.HB_TIMEOUT(HB_TIMEOUT)) u_wdog_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .hb        (hb_a),
        .power_on  (power_on_A),
        .reset_sig (reset_a_signal),
        .fault     (fault_a)
    );

    hb_watchdog #(.HB_TIMEOUT(HB_TIMEOUT)) u_wdog_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .hb        (hb_b),
        .power_on  (power_on_B),
        .reset_sig (reset_b_signal),
        .fault     (fault_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= A_HOST;
            guard_cnt <= 16'd0;
            switch    <= 1'b0;
            host_en_a <= 1'b1;
            host_en_b <= 1'b0;
            both_fail <= 1'b0;
            swi_event <= 1'b0;
        end else begin
            swi_event <= 1'b0;
            both_fail <= fault_a & fault_b;
            case (state)
                A_HOST: begin
                    // An operator request, even one naming the current host,
                    // outranks the fault path for that cycle.
                    if (force_swi) begin
                        if (com_swi) begin
                            state     <= GUARD_TO_B;
                            guard_cnt <= 16'd0;
                            host_en_a <= 1'b0;
                            host_en_b <= 1'b0;
                        end
                    end else if (fault_a && !fault_b && !both_fail) begin
                        state     <= GUARD_TO_B;
                        guard_cnt <= 16'd0;
                        host_en_a <= 1'b0;
                        host_en_b <= 1'b0;
                    end
                end
                GUARD_TO_B: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state     <= B_HOST;
                        switch    <= 1'b1;
                        host_en_b <= 1'b1;
                        swi_event <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt + 16'd1;
                    end
                end
                B_HOST: begin
                    if (force_swi) begin
                        if (!com_swi) begin
                            state     <= GUARD_TO_A;
                            guard_cnt <= 16'd0;
                            host_en_a <= 1'b0;
                            host_en_b <= 1'b0;
                        end
                    end else if (fault_b && !fault_a && !both_fail) begin
                        state     <= GUARD_TO_A;
                        guard_cnt <= 16'd0;
                        host_en_a <= 1'b0;
                        host_en_b <= 1'b0;
                    end
                end
                GUARD_TO_A: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state     <= A_HOST;
                        switch    <= 1'b0;
                        host_en_a <= 1'b1;
                        swi_event <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= A_HOST;
                    switch    <= 1'b0;
                    host_en_a <= 1'b1;
                    host_en_b <= 1'b0;
                end
            endcase
        end
    end

endmodule
